dmem_arbiter: RTL

Single-port data-RAM arbiter placed between the pipeline's MEM stage and the data RAM. It shares the RAM with a display/debug read port. The CPU has priority. The debug port is served in idle MEM cycles, and a bounded-wait starvation guard forces a one-cycle CPU stall when the debug port has waited too long. It replaces the direct MEM-stage connection to the RAM and feeds a stall into the pipeline enables.

---
 rtl/dmem_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter between the MEM stage and a debug read port.
// The CPU normally wins the RAM. The debug port is served in CPU-idle cycles.
// A bounded-wait guard forces a single CPU stall so the debug port cannot starve.
module dmem_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_en,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ack,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic [15:0]   stall_cnt
);

  typedef enum logic [1:0] {IDLE, FORCE, ACK} state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic       dbg_gnt, cpu_gnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // The CPU read data comes straight from the RAM, so reads add no latency.
  assign cpu_rdata = ram_dout;

  // Decide who owns the RAM this cycle, then steer the RAM port to that owner.
  always_comb begin
    dbg_gnt   = dbg_req & (((state == IDLE) & ~cpu_en) | (state == FORCE));
    cpu_gnt   = cpu_en & ~dbg_gnt;
    ram_addr  = dbg_gnt ? dbg_addr : cpu_addr;
    ram_din   = cpu_wdata;
    ram_we    = cpu_gnt & cpu_we & ~rst;
    cpu_stall = (state == FORCE) & cpu_en & dbg_req & ~rst;
  end

  // Next-state logic: count how long the debug port has been denied. Force a grant at the limit.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      IDLE: begin
        if (!dbg_req) begin
          wait_nxt = '0;
        end else if (!cpu_en) begin
          state_nxt = ACK;
          wait_nxt  = '0;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
          if (wait_cnt + 8'd1 == MAX_WAIT_C) state_nxt = FORCE;
        end
      end
      FORCE: begin
        // A withdrawn request just falls back to IDLE without a grant.
        wait_nxt  = '0;
        state_nxt = dbg_req ? ACK : IDLE;
      end
      ACK: begin
        // Never grant debug here, so a stalled CPU access always completes now.
        wait_nxt  = '0;
        state_nxt = IDLE;
      end
      default: begin
        wait_nxt  = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State, debug read capture, ack pulse and the stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      dbg_ack  <= dbg_gnt;
      if (dbg_gnt)   dbg_rdata <= ram_dout;
      if (cpu_stall) stall_cnt <= sat_inc16(stall_cnt);
    end
  end

endmodule
